// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse_meter measurement stage.
`timescale 1ns/1ps

package pulse_meter_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } pulse_meter_state_e;

  // Default width of the high/low time counters.
  localparam int CNT_W_DEFAULT = 16;

  // Largest count a width-bit level counter may reach before the level is
  // declared stuck (2^width - 1).
  function automatic logic [63:0] cnt_sat(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pulse_meter_sync.sv
// Synchronizer and edge detector for the asynchronous waveform input.
// s is the synchronized level; rise/fall are single-cycle edge strobes
// derived from s and its one-cycle-delayed copy.
// SYNC_STAGES must be at least 2.
`timescale 1ns/1ps

module pulse_meter_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Delayed copy of the synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_meter.sv
// Pulse meter: measures high time, low time and period of an asynchronous
// waveform in clk cycles. Results are published together with a one-cycle
// meas_valid strobe once a full high+low period has been observed.
// Optional feature macro: PULSE_METER_MINMAX_EN adds min_max_clr and the
// running period_min/period_max tracker.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | measurement disabled, counter held
// WAIT_RISE | armed, waiting for a rising edge to start a clean period
// MEAS_HIGH | counting the high level of the current period
// MEAS_LOW  | counting the low level; next rise closes the period
`timescale 1ns/1ps

module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
`ifdef PULSE_METER_MINMAX_EN
  input  logic             min_max_clr,
`endif
  output logic             meas_valid,
  output logic [CNT_W-1:0] ton_cnt,
  output logic [CNT_W-1:0] toff_cnt,
  output logic [CNT_W:0]   period_cnt,
`ifdef PULSE_METER_MINMAX_EN
  output logic [CNT_W:0]   period_min,
  output logic [CNT_W:0]   period_max,
`endif
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pulse_meter_state_e state_q;
  pulse_meter_state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ton_r;

  logic sig_s;
  logic rise;
  logic fall;
  logic sat_hit;

  logic cnt_set_one;
  logic cnt_step;
  logic ton_capture;
  logic result_load;
  logic timeout_set;

  // The synchronized level itself is not needed here; only its edges are.
  logic sig_level_unused;
  assign sig_level_unused = sig_s;

  pulse_meter_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s      (sig_s),
    .rise   (rise),
    .fall   (fall)
  );

  // A level that has already lasted CNT_SAT cycles is treated as stuck,
  // even if an edge arrives in the same cycle.
  assign sat_hit = (cnt_q == CNT_SAT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a low enable overrides any edge in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (sat_hit)   state_d = WAIT_RISE;
          else if (fall) state_d = MEAS_LOW;
        end
        MEAS_LOW: begin
          if (sat_hit)   state_d = WAIT_RISE;
          else if (rise) state_d = MEAS_HIGH;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode: datapath control strobes for the current state.
  always_comb begin
    cnt_set_one = 1'b0;
    cnt_step    = 1'b0;
    ton_capture = 1'b0;
    result_load = 1'b0;
    timeout_set = 1'b0;
    if (en) begin
      case (state_q)
        WAIT_RISE: begin
          cnt_set_one = rise;
        end
        MEAS_HIGH: begin
          if (sat_hit) begin
            timeout_set = 1'b1;
          end else if (rise || fall) begin
            cnt_set_one = 1'b1;
            ton_capture = fall;
          end else begin
            cnt_step = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (sat_hit) begin
            timeout_set = 1'b1;
          end else if (rise || fall) begin
            cnt_set_one = 1'b1;
            result_load = rise;
          end else begin
            cnt_step = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Level counter: restarts at 1 on each accepted edge, held outside MEAS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_set_one) begin
      cnt_q <= CNT_ONE;
    end else if (cnt_step) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // High time of the period in progress, kept until the closing rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ton_r <= '0;
    end else if (ton_capture) begin
      ton_r <= cnt_q;
    end
  end

  // Result registers change only when a full period closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ton_cnt    <= '0;
      toff_cnt   <= '0;
      period_cnt <= '0;
    end else if (result_load) begin
      ton_cnt    <= ton_r;
      toff_cnt   <= cnt_q;
      period_cnt <= {1'b0, ton_r} + {1'b0, cnt_q};
    end
  end

  // One-cycle strobe aligned with the freshly loaded results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= result_load;
    end
  end

  // Sticky stuck-level flag; the next good result clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end else if (result_load) begin
      timeout <= 1'b0;
    end
  end

`ifdef PULSE_METER_MINMAX_EN
  logic mm_empty;

  // Running min/max of published periods; clear wins over a same-cycle
  // result, which is then simply not recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_min <= '0;
      period_max <= '0;
      mm_empty   <= 1'b1;
    end else if (min_max_clr) begin
      period_min <= '1;
      period_max <= '0;
      mm_empty   <= 1'b1;
    end else if (meas_valid) begin
      mm_empty <= 1'b0;
      if (mm_empty) begin
        period_min <= period_cnt;
        period_max <= period_cnt;
      end else begin
        if (period_cnt < period_min) period_min <= period_cnt;
        if (period_cnt > period_max) period_max <= period_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter (CNT_W=8 so timeouts are short).
// Build with PULSE_METER_MINMAX_EN defined to also exercise min/max tracking.
`timescale 1ns/1ps

module tb_pulse_meter;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic en     = 1'b0;
  logic sig_in = 1'b0;

  logic             meas_valid;
  logic [CNT_W-1:0] ton_cnt;
  logic [CNT_W-1:0] toff_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             timeout;
`ifdef PULSE_METER_MINMAX_EN
  localparam int MM_ONES = (1 << (CNT_W + 1)) - 1;
  logic             min_max_clr = 1'b0;
  logic [CNT_W:0]   period_min;
  logic [CNT_W:0]   period_max;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
`ifdef PULSE_METER_MINMAX_EN
    .min_max_clr (min_max_clr),
    .period_min  (period_min),
    .period_max  (period_max),
`endif
    .meas_valid  (meas_valid),
    .ton_cnt     (ton_cnt),
    .toff_cnt    (toff_cnt),
    .period_cnt  (period_cnt),
    .timeout     (timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: works on the stream of clk-sampled input levels,
  // delayed by the synchronizer depth, and reasons in terms of level runs.
  // A period is reported when a rise closes a complete high run followed
  // by a complete low run, both observed since measurement was armed.
  // ---------------------------------------------------------------------
  logic [SYNC-1:0] m_pipe;
  logic m_prev;
  int   m_len;      // samples in the run that ends just before the current one
  bit   m_armed;    // enable was already high on the previous edge
  bit   m_track;    // a rise has been seen since arming
  bit   m_in_low;
  int   m_hi;
  bit   e_valid;
  int   e_ton, e_toff, e_period;
  bit   e_timeout;
`ifdef PULSE_METER_MINMAX_EN
  int   e_min, e_max;
  bit   e_empty;
`endif

  initial begin
    logic cur;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pipe = '0; m_prev = 1'b0; m_len = 0;
        m_armed = 0; m_track = 0; m_in_low = 0; m_hi = 0;
        e_valid = 0; e_ton = 0; e_toff = 0; e_period = 0; e_timeout = 0;
`ifdef PULSE_METER_MINMAX_EN
        e_min = 0; e_max = 0; e_empty = 1;
`endif
      end else begin
`ifdef PULSE_METER_MINMAX_EN
        if (min_max_clr) begin
          e_min = MM_ONES; e_max = 0; e_empty = 1;
        end else if (e_valid) begin
          if (e_empty || e_period < e_min) e_min = e_period;
          if (e_empty || e_period > e_max) e_max = e_period;
          e_empty = 0;
        end
`endif
        cur = m_pipe[SYNC-1];
        e_valid = 0;
        if (!en) begin
          m_armed = 0; m_track = 0;
        end else if (!m_armed) begin
          m_armed = 1;
        end else if (m_track && m_len >= SAT) begin
          e_timeout = 1; m_track = 0;
        end else if (cur && !m_prev) begin
          if (m_track && m_in_low) begin
            e_ton = m_hi; e_toff = m_len; e_period = m_hi + m_len;
            e_valid = 1; e_timeout = 0;
          end
          m_track = 1; m_in_low = 0;
        end else if (!cur && m_prev && m_track) begin
          m_hi = m_len; m_in_low = 1;
        end
        m_len  = (cur != m_prev) ? 1 : m_len + 1;
        m_prev = cur;
        m_pipe = {m_pipe[SYNC-2:0], sig_in};
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("meas_valid", meas_valid, e_valid);
      chk("ton_cnt", ton_cnt, e_ton);
      chk("toff_cnt", toff_cnt, e_toff);
      chk("period_cnt", period_cnt, e_period);
      chk("timeout", timeout, e_timeout);
`ifdef PULSE_METER_MINMAX_EN
      chk("period_min", period_min, e_min);
      chk("period_max", period_max, e_max);
`endif
    end
  end

  // Count published results for the hand-computed checks.
  int n_valid = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (meas_valid === 1'b1) n_valid++;
    end
  end

  task automatic pulse(input int hi_ns, input int lo_ns);
    sig_in = 1'b1;
    #(hi_ns);
    sig_in = 1'b0;
    #(lo_ns);
  endtask

  task automatic restart();
    @(negedge clk) en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nv;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst meas_valid", meas_valid, 0);
    chk("rst ton_cnt", ton_cnt, 0);
    chk("rst toff_cnt", toff_cnt, 0);
    chk("rst period_cnt", period_cnt, 0);
    chk("rst timeout", timeout, 0);
    @(negedge clk) rst_n = 1'b1;

    // 50 MHz square wave: every closed period is 1 + 1.
    restart();
    nv = n_valid;
    for (int i = 0; i < 20; i++) pulse(10, 10);
    repeat (6) @(negedge clk);
    chk("sq50 count", n_valid - nv, 19);
    chk("sq50 ton", ton_cnt, 1);
    chk("sq50 toff", toff_cnt, 1);
    chk("sq50 period", period_cnt, 2);

    // 10 MHz 30% duty, 2 ns phase offset.
    restart();
    #2;
    nv = n_valid;
    pulse(30, 70);
    chk("d30 none before 2nd rise", n_valid - nv, 0);
    for (int i = 0; i < 3; i++) pulse(30, 70);
    repeat (6) @(negedge clk);
    chk("d30 count", n_valid - nv, 3);
    chk("d30 ton", ton_cnt, 3);
    chk("d30 toff", toff_cnt, 7);
    chk("d30 period", period_cnt, 10);

    // Stuck-high level, then recovery with a 40/60 wave.
    restart();
    nv = n_valid;
    sig_in = 1'b1;
    repeat (270) @(negedge clk);
    chk("stuck timeout", timeout, 1);
    chk("stuck no valid", n_valid - nv, 0);
    sig_in = 1'b0;
    #60;
    for (int i = 0; i < 3; i++) pulse(40, 60);
    repeat (6) @(negedge clk);
    chk("recover count", n_valid - nv, 2);
    chk("recover ton", ton_cnt, 4);
    chk("recover toff", toff_cnt, 6);
    chk("recover period", period_cnt, 10);
    chk("recover timeout clr", timeout, 0);

    // Enable dropped during the low phase: the partial period is discarded.
    restart();
    pulse(30, 70);
    pulse(30, 70);
    sig_in = 1'b1;
    #30;
    sig_in = 1'b0;
    #20;
    @(negedge clk) en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    nv = n_valid;
    #20;
    pulse(50, 50);
    chk("abort no valid", n_valid - nv, 0);
    chk("abort ton held", ton_cnt, 3);
    pulse(50, 50);
    chk("abort resume count", n_valid - nv, 1);
    chk("abort resume ton", ton_cnt, 5);
    chk("abort resume toff", toff_cnt, 5);

    // Asynchronous reset in the middle of a period.
    pulse(30, 70);
    pulse(30, 70);
    sig_in = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst meas_valid", meas_valid, 0);
    chk("arst ton_cnt", ton_cnt, 0);
    chk("arst toff_cnt", toff_cnt, 0);
    chk("arst period_cnt", period_cnt, 0);
    chk("arst timeout", timeout, 0);
    sig_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nv = n_valid;
    for (int i = 0; i < 3; i++) pulse(30, 70);
    repeat (6) @(negedge clk);
    chk("post-rst count", n_valid - nv, 2);
    chk("post-rst ton", ton_cnt, 3);
    chk("post-rst toff", toff_cnt, 7);

`ifdef PULSE_METER_MINMAX_EN
    // Periods 10, 12, 8 then a clear and a single 9.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(50, 50);
    pulse(60, 60);
    pulse(40, 40);
    sig_in = 1'b1;
    #40;
    chk("mm min", period_min, 8);
    chk("mm max", period_max, 12);
    sig_in = 1'b0;
    #20;
    min_max_clr = 1'b1;
    #10;
    min_max_clr = 1'b0;
    #20;
    pulse(40, 40);
    chk("mm clr min", period_min, 9);
    chk("mm clr max", period_max, 9);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
